pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
// PURPOSE
//   Parametrised elastic pipeline register for inter-stage boundaries
//   (IF/ID, ID/EX, ...). Carries an opaque WIDTH-bit payload with a
//   valid/ready handshake, synchronous flush (bubble insertion) and an
//   optional 2-entry skid buffer so that in_ready has no combinational
//   path from out_ready. A saturating stall counter supports performance debug.
// PARAMETERS
//   WIDTH   96      payload width in bits (e.g. {Instr, PC, PCPlus4})
//   BUBBLE  0       WIDTH-bit value driven on out_data when empty or flushed
//   SKID    1       1: 2-entry skid buffer (registered in_ready); 0: single entry
//   CNT_W   16      stall counter width
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   reset      in   1      synchronous reset, active-low (0 = reset)
//   flush      in   1      synchronous flush; discards all held entries
//   in_valid   in   1      upstream presents a payload
//   in_ready   out  1      stage accepts a payload this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      stage holds a payload for downstream
//   out_ready  in   1      downstream accepts the payload this cycle
//   out_data   out  WIDTH  head payload (BUBBLE when out_valid = 0)
//   occupancy  out  2      number of entries held (0..2; max 1 if SKID = 0)
//   stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//   - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Priority per edge: reset (reset = 0) > flush > normal transfer.
//   - Reset: state EMPTY, main and skid registers = BUBBLE, out_valid = 0,
//     occupancy = 0, stall_cnt = 0. in_ready = 0 while reset = 0.
//   - Flush: next state EMPTY, main/skid = BUBBLE. in_ready is forced to 0
//     in a flush cycle, so in_data is never captured. stall_cnt is unaffected.
//   - Latency: an accepted payload appears on out_data the next cycle.
//     Order is strictly FIFO; payloads are never dropped or duplicated
//     except by flush.
//   - States: EMPTY (occ 0), FULL (occ 1, main valid),
//     SKID (occ 2, main + skid valid; only reachable if SKID = 1).
//     EMPTY: in_fire -> FULL, main <= in_data.
//     FULL:  in_fire & out_fire  -> FULL, main <= in_data.
//            in_fire & !out_fire -> SKID, skid <= in_data.
//            !in_fire & out_fire -> EMPTY, main <= BUBBLE.
//            neither             -> hold.
//     SKID:  out_fire -> FULL, main <= skid, skid <= BUBBLE; else hold.
//   - in_ready: SKID = 1: (state != SKID) & !flush & reset (registered
//     state only, no out_ready path). SKID = 0: (state == EMPTY | out_ready)
//     & !flush & reset (same-cycle pass-through).
//   - out_valid = (state != EMPTY); out_data = main register.
//   - Payload held stable while out_valid & !out_ready (no change on out_data).
//   - stall_cnt: +1 each cycle with out_valid & !out_ready and no flush;
//     holds at 2^CNT_W-1; cleared only by reset.
//   - in_data is ignored when in_fire = 0; out_ready is ignored when out_valid = 0.
// TESTING
//   1. Reset = 0 for 2 cycles with in_valid = 1, in_data = 0xA5 -> out_valid = 0,
//      out_data = BUBBLE, occupancy = 0, stall_cnt = 0, in_ready = 0.
//   2. Stream 1,2,3 back-to-back with out_ready = 1 -> out_data 1,2,3 on
//      consecutive cycles, each one cycle after acceptance, occupancy = 1.
//   3. SKID = 1: accept 7, hold out_ready = 0, offer 8 -> occupancy = 2,
//      in_ready = 0, out_data = 7 stable; release -> 7 then 8, no loss.
//   4. Occupancy 2, flush = 1 with in_valid = 1 -> next cycle out_valid = 0,
//      out_data = BUBBLE, offered payload not captured.
//   5. CNT_W = 3, out_ready = 0 for 10 cycles while full -> stall_cnt = 7
//      (saturated); flush leaves it at 7; reset clears it to 0.
//   6. SKID = 0, full with out_ready = 1 and in_valid = 1 -> in_ready = 1 in
//      the same cycle and a new payload replaces the old on the next edge.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Elastic pipeline register with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_hs #(
    parameter int unsigned       WIDTH  = 96,
    parameter logic [WIDTH-1:0]  BUBBLE = '0,
    parameter bit                SKID   = 1'b1,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic             in_fire;
    logic             out_fire;

    // With the skid buffer, in_ready depends only on registered state, so
    // there is no combinational path from out_ready to in_ready.
    always_comb begin
        in_ready = 1'b0;
        if (SKID) begin
            in_ready = (state_q != ST_SKID) && !flush && reset;
        end else begin
            in_ready = ((state_q == ST_EMPTY) || out_ready) && !flush && reset;
        end
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign stall_cnt = stall_q;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_FULL: occupancy = 2'd1;
            ST_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else if (flush) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_q <= ST_FULL;
                        main_q  <= in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state_q <= ST_SKID;
                        skid_q  <= in_data;
                    end else if (out_fire) begin
                        state_q <= ST_EMPTY;
                        main_q  <= BUBBLE;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_q <= ST_FULL;
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    main_q  <= BUBBLE;
                    skid_q  <= BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a skid instance (CNT_W=3) and a pass-through
// instance share stimulus; each is compared against a queue-based model.
module tb_pipe_stage_hs;

    localparam logic [15:0] BUB_A = 16'hBEEF;
    localparam logic [15:0] BUB_B = 16'h0F0F;
    localparam int          MAX_A = 7;
    localparam int          MAX_B = 65535;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [15:0] a_out_data;
    logic [1:0]  a_occ;
    logic [2:0]  a_stall;

    logic        b_in_ready, b_out_valid;
    logic [15:0] b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    int checks   = 0;
    int failures = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          stall_a = 0;
    int          stall_b = 0;

    pipe_stage_hs #(
        .WIDTH (16),
        .BUBBLE(BUB_A),
        .SKID  (1'b1),
        .CNT_W (3)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (a_in_ready),
        .in_data  (in_data),
        .out_valid(a_out_valid),
        .out_ready(out_ready),
        .out_data (a_out_data),
        .occupancy(a_occ),
        .stall_cnt(a_stall)
    );

    pipe_stage_hs #(
        .WIDTH (16),
        .BUBBLE(BUB_B),
        .SKID  (1'b0),
        .CNT_W (16)
    ) u_pass (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (b_in_ready),
        .in_data  (in_data),
        .out_valid(b_out_valid),
        .out_ready(out_ready),
        .out_data (b_out_data),
        .occupancy(b_occ),
        .stall_cnt(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare both DUTs to the model, then advance the model.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [15:0] d, input logic ordy);
        logic rdy_a, rdy_b;
        @(negedge clk);
        reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        rdy_a = r && !f && (qa.size() < 2);
        rdy_b = r && !f && ((qb.size() == 0) || ordy);

        check("a_in_ready",  32'(a_in_ready),  32'(rdy_a));
        check("a_out_valid", 32'(a_out_valid), 32'(qa.size() > 0));
        check("a_out_data",  32'(a_out_data),  32'((qa.size() > 0) ? qa[0] : BUB_A));
        check("a_occupancy", 32'(a_occ),       32'(qa.size()));
        check("a_stall_cnt", 32'(a_stall),     32'(stall_a));
        check("b_in_ready",  32'(b_in_ready),  32'(rdy_b));
        check("b_out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
        check("b_out_data",  32'(b_out_data),  32'((qb.size() > 0) ? qb[0] : BUB_B));
        check("b_occupancy", 32'(b_occ),       32'(qb.size()));
        check("b_stall_cnt", 32'(b_stall),     32'(stall_b));

        @(posedge clk);
        if (!r) begin
            qa.delete(); qb.delete();
            stall_a = 0; stall_b = 0;
        end else if (f) begin
            qa.delete(); qb.delete();
        end else begin
            if (qa.size() > 0 && !ordy) stall_a = (stall_a < MAX_A) ? stall_a + 1 : MAX_A;
            if (qb.size() > 0 && !ordy) stall_b = (stall_b < MAX_B) ? stall_b + 1 : MAX_B;
            if (qa.size() > 0 && ordy) void'(qa.pop_front());
            if (iv && rdy_a) qa.push_back(d);
            if (qb.size() > 0 && ordy) void'(qb.pop_front());
            if (iv && rdy_b) qb.push_back(d);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 16'hA5; out_ready = 1'b0;

        // Reset held low while a payload is offered
        step(0, 0, 1, 16'hA5, 0);
        step(0, 0, 1, 16'hA5, 0);

        // Back-to-back stream with downstream always ready
        step(1, 0, 1, 16'd1, 1);
        step(1, 0, 1, 16'd2, 1);
        step(1, 0, 1, 16'd3, 1);
        step(1, 0, 0, 16'd0, 1);
        step(1, 0, 0, 16'd0, 1);

        // Skid fill, back-pressure, then drain in order
        step(1, 0, 1, 16'd7, 0);
        step(1, 0, 1, 16'd8, 0);
        step(1, 0, 1, 16'd9, 0);
        step(1, 0, 0, 16'd0, 0);
        step(1, 0, 0, 16'd0, 1);
        step(1, 0, 0, 16'd0, 1);
        step(1, 0, 0, 16'd0, 1);

        // Flush with two entries held and a payload offered
        step(1, 0, 1, 16'd7, 0);
        step(1, 0, 1, 16'd8, 0);
        step(1, 1, 1, 16'h55, 0);
        step(1, 0, 0, 16'd0, 0);

        // Stall counter saturation, survives flush, cleared by reset
        step(1, 0, 1, 16'd11, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 16'd0, 0);
        step(1, 1, 0, 16'd0, 0);
        step(1, 0, 0, 16'd0, 0);
        step(0, 0, 0, 16'd0, 0);
        step(1, 0, 0, 16'd0, 0);

        // Pass-through replacement while full and downstream ready
        step(1, 0, 1, 16'd20, 1);
        step(1, 0, 1, 16'd21, 1);
        step(1, 0, 1, 16'd22, 1);
        step(1, 0, 0, 16'd0, 1);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 16'($urandom),
                 ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
